event_packer: RTL and testbench

Event builder placed directly downstream of the per-channel DSP pipeline. Groups per-channel peak/area results and the coincidence flag into one timestamped event record per trigger window, buffers complete records in a small FIFO, and serialises them as a byte stream with valid/ready handshake toward the UART transmitter.

---
 rtl/event_packer_pkg.sv | 25 ++
 rtl/event_packer_if.sv | 9 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/event_packer.sv | 202 ++++++++++++++++++++
 tb/tb_event_packer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/event_packer_pkg.sv
// Shared types and record layout constants for the event packer.
package event_packer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCommit
  } state_e;

  localparam logic [7:0]  HEADER_BYTE = 8'hA5;
  localparam int unsigned TS_BYTES    = 4;
  localparam int unsigned PEAK_BYTES  = 2;
  localparam int unsigned AREA_BYTES  = 3;

  typedef struct packed {
    logic       coinc;
    logic [6:0] hit;
  } flags_t;

  // Header byte + timestamp + flags byte, then peak/area per channel.
  function automatic int unsigned record_bytes(int unsigned n_ch);
    return 2 + TS_BYTES + n_ch * (PEAK_BYTES + AREA_BYTES);
  endfunction

endpackage

// File: rtl/event_packer_if.sv
// Byte stream with valid/ready handshake toward the UART transmitter.
interface event_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read port; Depth must be a power of two.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] DepthCnt = Depth[AddrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   count_q, count_d;
  logic             wr_acc, rd_acc;

  // Full is taken from the registered count, so a write when full is refused
  // even if a pop happens in the same cycle.
  assign full_o    = (count_q == DepthCnt);
  assign empty_o   = (count_q == '0);
  assign wr_acc    = wr_en_i & ~full_o;
  assign rd_acc    = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (!wr_acc && rd_acc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/event_packer.sv
// Collects per-channel peak/area results into timestamped records, buffers them
// and streams them out one byte per handshake.
module event_packer
  import event_packer_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned N_P        = 12,
  parameter int unsigned N_A        = 20,
  parameter int unsigned N_TS       = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0][N_P-1:0] A_peak,
  input  logic [N_CH-1:0]          peak_ready,
  input  logic [N_CH-1:0][N_A-1:0] A_area,
  input  logic [N_CH-1:0]          area_ready,
  input  logic                     coincidence_flag,
  input  logic [15:0]              window_len,
  event_packer_if.master           out_if,
  output logic [15:0]              dropped_count,
  output logic                     busy
);
  localparam int unsigned RecBytes = record_bytes(N_CH);
  localparam int unsigned RecW     = RecBytes * 8;
  localparam int unsigned HdrBytes = 2 + TS_BYTES;
  localparam int unsigned ChBytes  = PEAK_BYTES + AREA_BYTES;
  localparam int unsigned IdxW     = $clog2(RecBytes);
  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [N_TS-1:0]         ts_q, ev_ts_q, ev_ts_d;
  logic [15:0]             win_q, win_d;
  logic [N_CH-1:0]         pk_vld_q, pk_vld_d, ar_vld_q, ar_vld_d;
  logic [N_CH-1:0][N_P-1:0] pk_q, pk_d;
  logic [N_CH-1:0][N_A-1:0] ar_q, ar_d;
  logic                    coinc_q, coinc_d;
  logic [15:0]             drop_q, drop_d;
  logic                    capture;

  logic                    fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_cnt;
  logic [RecW-1:0]         rec_wr, rec_rd;
  flags_t                  flags;

  logic                    out_valid_q, out_valid_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [7:0]              rec_bytes [RecBytes];
  logic                    last_byte, accept;

  always_comb begin
    state_d  = state_q;
    ev_ts_d  = ev_ts_q;
    win_d    = win_q;
    pk_vld_d = pk_vld_q;
    ar_vld_d = ar_vld_q;
    pk_d     = pk_q;
    ar_d     = ar_q;
    coinc_d  = coinc_q;
    drop_d   = drop_q;
    fifo_wr  = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|peak_ready) begin
          capture = 1'b1;
          ev_ts_d = ts_q;
          coinc_d = coincidence_flag;
          // Window of 0 or 1 commits in the very next cycle.
          if (window_len <= 16'd1) begin
            state_d = StCommit;
          end else begin
            win_d   = window_len - 16'd2;
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        capture = 1'b1;
        if (coincidence_flag) coinc_d = 1'b1;
        if (win_q == 16'd0) state_d = StCommit;
        else                win_d   = win_q - 16'd1;
      end
      StCommit: begin
        if (!fifo_full)              fifo_wr = 1'b1;
        else if (drop_q != 16'hFFFF) drop_d  = drop_q + 16'd1;
        pk_vld_d = '0;
        ar_vld_d = '0;
        pk_d     = '0;
        ar_d     = '0;
        coinc_d  = 1'b0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // First strobe per channel wins; later ones in the same window are ignored.
    if (capture) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (peak_ready[c] && !pk_vld_q[c]) begin
          pk_vld_d[c] = 1'b1;
          pk_d[c]     = A_peak[c];
        end
        if (area_ready[c] && !ar_vld_q[c]) begin
          ar_vld_d[c] = 1'b1;
          ar_d[c]     = A_area[c];
        end
      end
    end
  end

  assign flags = '{coinc: coinc_q, hit: 7'(ar_vld_q)};

  always_comb begin
    rec_wr = '0;
    rec_wr[RecW-1 -: 8]  = HEADER_BYTE;
    rec_wr[RecW-9 -: 32] = 32'(ev_ts_q);
    rec_wr[RecW-41 -: 8] = flags;
    for (int c = 0; c < int'(N_CH); c++) begin
      rec_wr[RecW-1-8*(HdrBytes+ChBytes*c) -: 16] = 16'($signed(pk_q[c]));
      rec_wr[RecW-1-8*(HdrBytes+ChBytes*c+PEAK_BYTES) -: 24] = 24'($signed(ar_q[c]));
    end
  end

  sync_fifo #(
    .Width(RecW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .wr_en_i  (fifo_wr),
    .wr_data_i(rec_wr),
    .rd_en_i  (fifo_rd),
    .rd_data_o(rec_rd),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_cnt)
  );

  // Serialiser reads the FIFO head in place and pops after its last byte.
  always_comb begin
    for (int b = 0; b < int'(RecBytes); b++) begin
      rec_bytes[b] = rec_rd[RecW-1-8*b -: 8];
    end
  end

  assign last_byte = (idx_q == IdxW'(RecBytes - 1));
  assign accept    = out_valid_q & out_if.out_ready;
  assign fifo_rd   = accept & last_byte;

  always_comb begin
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    if (!out_valid_q) begin
      out_valid_d = ~fifo_empty;
      idx_d       = '0;
    end else if (accept) begin
      if (last_byte) begin
        idx_d       = '0;
        out_valid_d = (fifo_cnt > CntW'(1)) | fifo_wr;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_valid_q ? rec_bytes[idx_q] : 8'h00;
  assign dropped_count    = drop_q;
  assign busy             = (state_q != StIdle) | ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      ev_ts_q     <= '0;
      win_q       <= '0;
      pk_vld_q    <= '0;
      ar_vld_q    <= '0;
      pk_q        <= '0;
      ar_q        <= '0;
      coinc_q     <= 1'b0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_q + 1'b1;
      ev_ts_q     <= ev_ts_d;
      win_q       <= win_d;
      pk_vld_q    <= pk_vld_d;
      ar_vld_q    <= ar_vld_d;
      pk_q        <= pk_d;
      ar_q        <= ar_d;
      coinc_q     <= coinc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
    end
  end

endmodule

// File: tb/tb_event_packer.sv
// Directed bench for event_packer: hand-computed records, timing and drop behaviour.
module tb_event_packer;
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0][11:0] a_peak;
  logic [1:0]       peak_ready;
  logic [1:0][19:0] a_area;
  logic [1:0]       area_ready;
  logic             coinc;
  logic [15:0]      window_len;
  logic [15:0]      dropped_count;
  logic             busy;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  rx_q [$];
  logic        stall_seen = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  logic [7:0]  exp_rec [16];
  logic [31:0] ts_exp;

  event_packer_if bus ();

  event_packer #(
    .N_CH(2), .N_P(12), .N_A(20), .N_TS(32), .FIFO_DEPTH(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .A_peak          (a_peak),
    .peak_ready      (peak_ready),
    .A_area          (a_area),
    .area_ready      (area_ready),
    .coincidence_flag(coinc),
    .window_len      (window_len),
    .out_if          (bus),
    .dropped_count   (dropped_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int i = 0;
    while (rx_q.size() < n && i < budget) begin
      step();
      i++;
    end
    chk(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_rec(input string tag);
    logic [7:0] b;
    if (rx_q.size() < 16) begin
      chk({tag, "_len"}, 32'(rx_q.size()), 32'd16);
    end else begin
      for (int i = 0; i < 16; i++) begin
        b = rx_q.pop_front();
        chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp_rec[i]));
      end
    end
  endtask

  // Two-channel event: 0x800 sign-extends to 0xF800, area -1 to 0xFFFFFF.
  task automatic two_ch_event();
    window_len = 16'd20;
    a_peak[0] = 12'h800;
    a_peak[1] = 12'h7FF;
    peak_ready = 2'b11;
    ts_exp = cyc;
    step();
    peak_ready = 2'b00;
    step();
    step();
    a_area[0] = 20'hFFFFF;
    a_area[1] = 20'h00005;
    area_ready = 2'b11;
    step();
    area_ready = 2'b00;
    step();
    coinc = 1'b1;
    step();
    coinc = 1'b0;
    exp_rec = '{8'hA5, ts_exp[31:24], ts_exp[23:16], ts_exp[15:8], ts_exp[7:0], 8'h83,
                8'hF8, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'hFF, 8'h00, 8'h00, 8'h05};
  endtask

  // Byte monitor; also checks that data holds while the consumer stalls.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) rx_q.push_back(bus.out_data);
    if (stall_seen && bus.out_valid === 1'b1) chk("stall_hold", 32'(bus.out_data), 32'(stall_data));
    stall_seen = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
    stall_data = bus.out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_peak = '0;
    peak_ready = '0;
    a_area = '0;
    area_ready = '0;
    coinc = 1'b0;
    window_len = 16'd50;
    bus.out_ready = 1'b1;
    #1 reset = 1'b1;
    step();
    step();
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_dropped", 32'(dropped_count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();
    reset = 1'b0;
    cyc = 0;

    // Single channel, open at ts=10, area at ts=20, window 50 -> commit at 60.
    repeat (10) step();
    a_peak[0] = 12'h123;
    peak_ready = 2'b01;
    step();
    peak_ready = 2'b00;
    repeat (9) step();
    a_area[0] = 20'h00400;
    area_ready = 2'b01;
    step();
    area_ready = 2'b00;
    repeat (40) step();
    chk("t1_valid_c61", 32'(bus.out_valid), 32'h0);
    chk("t1_busy_c61", 32'(busy), 32'h1);
    step();
    chk("t1_valid_c62", 32'(bus.out_valid), 32'h1);
    chk("t1_first_byte", 32'(bus.out_data), 32'hA5);
    wait_bytes("t1_wait", 16, 40);
    exp_rec = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h01, 8'h01, 8'h23,
                8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_rec("t1");

    // Both channels with coincidence, consumer always ready.
    two_ch_event();
    wait_bytes("t2_wait", 16, 60);
    check_rec("t2");

    // Same event with out_ready toggling every cycle.
    two_ch_event();
    for (int i = 0; i < 150 && rx_q.size() < 16; i++) begin
      bus.out_ready = ~bus.out_ready;
      step();
    end
    bus.out_ready = 1'b1;
    check_rec("t3");

    // window_len=0: commit next cycle, strobe during commit is ignored.
    repeat (5) step();
    window_len = 16'd0;
    a_peak[0] = 12'h055;
    peak_ready = 2'b01;
    ts_exp = cyc;
    step();
    a_peak[0] = 12'h0AA;
    step();
    peak_ready = 2'b00;
    chk("t4_valid_t2", 32'(bus.out_valid), 32'h0);
    chk("t4_busy_t2", 32'(busy), 32'h1);
    step();
    chk("t4_valid_t3", 32'(bus.out_valid), 32'h1);
    wait_bytes("t4_wait", 16, 30);
    exp_rec = '{8'hA5, ts_exp[31:24], ts_exp[23:16], ts_exp[15:8], ts_exp[7:0], 8'h00,
                8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_rec("t4");
    repeat (20) step();
    chk("t4_no_extra", 32'(rx_q.size()), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'h0);

    // Nine events into an 8-deep FIFO while the consumer is stalled.
    bus.out_ready = 1'b0;
    window_len = 16'd2;
    for (int k = 0; k < 9; k++) begin
      a_peak[0] = 12'h010 + 12'(k);
      peak_ready = 2'b01;
      step();
      peak_ready = 2'b00;
      repeat (3) step();
    end
    step();
    chk("t5_dropped", 32'(dropped_count), 32'd1);
    chk("t5_valid_stalled", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    repeat (128) step();
    chk("t5_bytes", 32'(rx_q.size()), 32'd128);
    chk("t5_valid_after", 32'(bus.out_valid), 32'h0);
    for (int k = 0; k < 8 && rx_q.size() >= 16; k++) begin
      logic [7:0] rb [16];
      for (int i = 0; i < 16; i++) rb[i] = rx_q.pop_front();
      chk($sformatf("t5_hdr%0d", k), 32'(rb[0]), 32'hA5);
      chk($sformatf("t5_peak%0d", k), 32'(rb[7]), 32'h10 + 32'(k));
    end

    // Reset while byte 7 of a record is on the bus.
    window_len = 16'd1;
    a_peak[0] = 12'h321;
    peak_ready = 2'b01;
    step();
    peak_ready = 2'b00;
    for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) step();
    chk("t6_valid_seen", 32'(bus.out_valid), 32'h1);
    repeat (7) step();
    chk("t6_byte7", 32'(bus.out_data), 32'h21);
    chk("t6_dropped_pre", 32'(dropped_count), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_valid_rst", 32'(bus.out_valid), 32'h0);
    chk("t6_data_rst", 32'(bus.out_data), 32'h0);
    chk("t6_partial", 32'(rx_q.size()), 32'd7);
    step();
    step();
    reset = 1'b0;
    repeat (30) step();
    chk("t6_no_resume", 32'(rx_q.size()), 32'd7);
    chk("t6_valid_post", 32'(bus.out_valid), 32'h0);
    chk("t6_dropped_post", 32'(dropped_count), 32'd0);
    chk("t6_busy_post", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
